// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and lane-shift helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } lsu_state_e;

   function automatic logic [4:0] byte_shift(input logic [1:0] off);
      return {off, 3'b000};
   endfunction

   function automatic logic [4:0] half_shift(input logic [1:0] off);
      return {off[1], 4'b0000};
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte/half lane handling: extract and extend a load lane, or merge a store lane into a word.
module load_store_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] ld_word,
   input  logic [31:0] rmw_word,
   input  logic [15:0] st_half,
   output logic [31:0] ld_value,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;

   always_comb begin
      byte_sel = 8'(ld_word >> byte_shift(byte_off));
      half_sel = 16'(ld_word >> half_shift(byte_off));
      ld_value = ld_word;
      case (funct3)
         F3_B:    ld_value = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ld_value = {24'h0, byte_sel};
         F3_H:    ld_value = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ld_value = {16'h0, half_sel};
         default: ld_value = ld_word;
      endcase

      if (funct3[1:0] == 2'b01) begin
         lane_mask = 32'h0000_ffff << half_shift(byte_off);
         lane_data = {16'h0, st_half} << half_shift(byte_off);
      end else begin
         lane_mask = 32'h0000_00ff << byte_shift(byte_off);
         lane_data = {24'h0, st_half[7:0]} << byte_shift(byte_off);
      end
      merged_word = (rmw_word & ~lane_mask) | lane_data;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide memory, with sub-word
// loads/stores built from lane extraction and read-modify-write.
//
//   state     | meaning
//   ST_IDLE   | ready; latch request and decode path or error
//   ST_LOAD   | memory read, capture extended lane
//   ST_STORE  | full-word write
//   ST_RMW_RD | read word for byte/half store
//   ST_RMW_WR | write word with lane replaced
//   ST_RESP   | one-cycle response pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter bit          CHECK_RANGE = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [31:0] load_data,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_MemWrite,
   output logic        mem_MemRead,
   input  logic [31:0] mem_read_data
);

   localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);
   localparam logic [31:0] ADDR_MASK  = ADDR_LIMIT - 32'd4;

   lsu_state_e  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] word_q, word_d;
   logic [31:0] load_data_q, load_data_d;
   logic        resp_error_q, resp_error_d;

   logic        req_err;
   logic [31:0] ld_value;
   logic [31:0] merged_word;

   load_store_align u_align (
      .funct3      (funct3_q),
      .byte_off    (addr_q[1:0]),
      .ld_word     (mem_read_data),
      .rmw_word    (word_q),
      .st_half     (sdata_q[15:0]),
      .ld_value    (ld_value),
      .merged_word (merged_word)
   );

   // Stores only exist for b/h/w, so any store funct3 with bit 2 set is illegal.
   always_comb begin
      req_err = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
             || (req_write && funct3[2])
             || ((funct3[1:0] == 2'b01) && address[0])
             || ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00))
             || (CHECK_RANGE && (address >= ADDR_LIMIT));
   end

   always_comb begin
      state_d        = state_q;
      funct3_d       = funct3_q;
      addr_d         = addr_q;
      sdata_d        = sdata_q;
      word_d         = word_q;
      load_data_d    = load_data_q;
      resp_error_d   = resp_error_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_MemRead    = 1'b0;
      mem_MemWrite   = 1'b0;
      mem_write_data = 32'h0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               funct3_d     = funct3;
               addr_d       = address;
               sdata_d      = store_data;
               load_data_d  = 32'h0;
               resp_error_d = req_err;
               if (req_err)                   state_d = ST_RESP;
               else if (!req_write)           state_d = ST_LOAD;
               else if (funct3[1:0] == 2'b10) state_d = ST_STORE;
               else                           state_d = ST_RMW_RD;
            end
         end
         ST_LOAD: begin
            mem_MemRead = 1'b1;
            load_data_d = ld_value;
            state_d     = ST_RESP;
         end
         ST_STORE: begin
            mem_MemWrite   = 1'b1;
            mem_write_data = sdata_q;
            state_d        = ST_RESP;
         end
         ST_RMW_RD: begin
            mem_MemRead = 1'b1;
            word_d      = mem_read_data;
            state_d     = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            mem_MemWrite   = 1'b1;
            mem_write_data = merged_word;
            state_d        = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         funct3_q     <= 3'b000;
         addr_q       <= 32'h0;
         sdata_q      <= 32'h0;
         word_q       <= 32'h0;
         load_data_q  <= 32'h0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         word_q       <= word_d;
         load_data_q  <= load_data_d;
         resp_error_q <= resp_error_d;
      end
   end

   // Without range checking, high address bits alias onto the memory index.
   assign mem_address = CHECK_RANGE ? {addr_q[31:2], 2'b00} : (addr_q & ADDR_MASK);
   assign load_data   = load_data_q;
   assign resp_error  = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests against a byte-level model.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] load_data;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_MemWrite;
   logic        mem_MemRead;
   logic [31:0] mem_read_data;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int checks = 0;
   int errors = 0;

   load_store_unit #(.MEM_WORDS(1024), .CHECK_RANGE(1'b1)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .funct3         (funct3),
      .address        (address),
      .store_data     (store_data),
      .resp_valid     (resp_valid),
      .resp_error     (resp_error),
      .load_data      (load_data),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_MemWrite   (mem_MemWrite),
      .mem_MemRead    (mem_MemRead),
      .mem_read_data  (mem_read_data)
   );

   always #5 clock = ~clock;

   assign mem_read_data = mem[mem_address[11:2]];
   always @(posedge clock) if (mem_MemWrite) mem[mem_address[11:2]] <= mem_write_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [31:0] w;
      w = ref_mem[a[11:2]];
      return 8'(w >> (int'(a[1:0]) * 8));
   endfunction

   // Reference behaviour expressed on bytes: access size, legality, alignment, range.
   task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, output bit err, output int lat,
                        output logic [31:0] ld, output int nrd, output int nwr);
      int size;
      bit legal;
      logic [31:0] w;
      int off;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || ((a % size) != 0) || (a >= 32'd4096);
      ld = 32'h0; nrd = 0; nwr = 0; lat = 1;
      if (err) return;
      if (!wr) begin
         lat = 2; nrd = 1;
         for (int i = 0; i < size; i++) ld = ld | (32'(ref_byte(a + i)) << (8 * i));
         if (f3 < 3'd4 && size < 4 && ld[8 * size - 1]) ld = ld | ~((32'd1 << (8 * size)) - 32'd1);
      end else begin
         nwr = 1;
         if (size == 4) lat = 2;
         else begin lat = 3; nrd = 1; end
         for (int i = 0; i < size; i++) begin
            w   = ref_mem[(a + i) >> 2];
            off = int'((a + i) % 4);
            w[8 * off +: 8] = 8'(sd >> (8 * i));
            ref_mem[(a + i) >> 2] = w;
         end
      end
   endtask

   task automatic do_req(input string tag, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
      bit e;
      int lat, nrd, nwr;
      int got_lat = 0, crd = 0, cwr = 0, both = 0, rdy = 0;
      logic [31:0] ld;
      model(wr, f3, a, sd, e, lat, ld, nrd, nwr);
      @(negedge clock);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; funct3 = f3; address = a; store_data = sd;
      @(posedge clock);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); funct3 = 3'($urandom);
      address = $urandom; store_data = $urandom;
      for (int c = 1; c <= 8 && got_lat == 0; c++) begin
         @(negedge clock);
         if (mem_MemRead)  begin crd++; chk({tag, " rd addr"}, mem_address, {a[31:2], 2'b00}); end
         if (mem_MemWrite) begin cwr++; chk({tag, " wr addr"}, mem_address, {a[31:2], 2'b00}); end
         if (mem_MemRead && mem_MemWrite) both++;
         if (req_ready) rdy++;
         if (resp_valid) got_lat = c;
      end
      chk({tag, " latency"}, 32'(got_lat), 32'(lat));
      chk({tag, " resp_error"}, 32'(resp_error), 32'(e));
      chk({tag, " load_data"}, load_data, ld);
      chk({tag, " read strobes"}, 32'(crd), 32'(nrd));
      chk({tag, " write strobes"}, 32'(cwr), 32'(nwr));
      chk({tag, " strobe overlap"}, 32'(both), 32'd0);
      chk({tag, " ready while busy"}, 32'(rdy), 32'd0);
      @(negedge clock);
      chk({tag, " resp pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, " load_data hold"}, load_data, ld);
      chk({tag, " mem word"}, mem[a[11:2]], ref_mem[a[11:2]]);
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem[idx] = v;
      ref_mem[idx] = v;
   endtask

   logic [31:0] b2b_addr [4];
   logic [31:0] exp_q [$];

   initial begin
      bit e;
      int lat, nrd, nwr, acc, nresp, last_resp, rdy_pulses;
      logic [31:0] ld;
      logic [31:0] a;

      for (int i = 0; i < 1024; i++) set_word(i, $urandom);
      set_word(4, 32'h80FF7F01);
      set_word(8, 32'h11223344);
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
      address = 32'h0; store_data = 32'h0;

      #3;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'd0);
      chk("reset mem_address", mem_address, 32'h0);
      chk("reset load_data", load_data, 32'h0);
      chk("reset resp_error", 32'(resp_error), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      do_req("lb 0x11", 1'b0, 3'b000, 32'h11, 32'h0);
      chk("lb 0x11 value", load_data, 32'h0000007F);
      do_req("lb 0x13", 1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb 0x13 value", load_data, 32'hFFFFFF80);
      do_req("lbu 0x13", 1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu 0x13 value", load_data, 32'h00000080);
      do_req("lh 0x12", 1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh 0x12 value", load_data, 32'hFFFF80FF);
      do_req("lhu 0x12", 1'b0, 3'b101, 32'h12, 32'h0);
      chk("lhu 0x12 value", load_data, 32'h000080FF);

      do_req("sb 0x21", 1'b1, 3'b000, 32'h21, 32'h000000AB);
      chk("sb 0x21 word", mem[8], 32'h1122AB44);
      set_word(8, 32'h11223344);
      do_req("sh 0x22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF);
      chk("sh 0x22 word", mem[8], 32'hBEEF3344);
      do_req("sw 0x24", 1'b1, 3'b010, 32'h24, 32'hDEADBEEF);
      chk("sw 0x24 word", mem[9], 32'hDEADBEEF);

      do_req("sh 0x23", 1'b1, 3'b001, 32'h23, 32'h1234);
      chk("sh 0x23 error", 32'(resp_error), 32'd1);
      do_req("lw 0x26", 1'b0, 3'b010, 32'h26, 32'h0);
      chk("lw 0x26 error", 32'(resp_error), 32'd1);
      do_req("f3 011", 1'b0, 3'b011, 32'h10, 32'h0);
      chk("f3 011 error", 32'(resp_error), 32'd1);
      do_req("lw 0x1000", 1'b0, 3'b010, 32'h1000, 32'h0);
      chk("lw 0x1000 error", 32'(resp_error), 32'd1);
      chk("lw 0x1000 load_data", load_data, 32'h0);

      // Reset while the read half of a byte store is in progress.
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b000; address = 32'h21; store_data = 32'h55;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      chk("rmw rd before reset", 32'(mem_MemRead), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async reset req_ready", 32'(req_ready), 32'd1);
      chk("async reset strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'd0);
      chk("async reset mem_address", mem_address, 32'h0);
      chk("async reset resp_error", 32'(resp_error), 32'd0);
      chk("async reset resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("after reset word", mem[8], ref_mem[8]);
      chk("after reset ready", 32'(req_ready), 32'd1);

      // Four loads with req_valid held high throughout.
      b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h24; b2b_addr[3] = 32'h40;
      acc = 0; nresp = 0; last_resp = -1; rdy_pulses = 0;
      req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; store_data = 32'h0;
      for (int c = 0; c < 40 && nresp < 4; c++) begin
         if (c > 0) @(negedge clock);
         if (resp_valid) begin
            if (exp_q.size() > 0) chk("b2b order", load_data, exp_q.pop_front());
            if (last_resp >= 0) chk("b2b spacing", 32'(c - last_resp), 32'd3);
            last_resp = c;
            nresp++;
         end
         if (req_ready) begin
            rdy_pulses++;
            chk("b2b ready vs resp", 32'(resp_valid), 32'd0);
            if (acc < 4) begin
               address = b2b_addr[acc];
               model(1'b0, 3'b010, b2b_addr[acc], 32'h0, e, lat, ld, nrd, nwr);
               exp_q.push_back(ld);
               acc++;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b responses", 32'(nresp), 32'd4);
      chk("b2b ready pulses", 32'(rdy_pulses), 32'd4);

      for (int n = 0; n < 80; n++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
         do_req("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
